stoch_mult_sequencer: RTL and testbench

- Job-level controller for the stochastic multiply datapath: two 31-bit LFSRs, 4-bit comparators, an XNOR or AND combiner, and a ones-counter.
- Accepts one multiply job at a time over a valid/ready request channel.
- Per job: seeds the LFSRs, fills the bitstream pipeline, accumulates over a fixed window, and returns the count and a rescaled probability over a valid/ready result channel.
- Sits between the top-level pin wrapper and the stochastic datapath, replacing free-running accumulation with a deterministic per-job sequence.

---
 rtl/stoch_pkg.sv | 21 ++
 rtl/stoch_mult_sequencer_lfsr31.sv | 26 ++
 rtl/stoch_mult_sequencer.sv | 172 +++++++++++++++++
 tb/tb_stoch_mult_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic multiply sequencer.
// Holds the job FSM state encoding and the 31-bit LFSR recurrence.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ACCUM,
        DONE
    } state_t;

    localparam int unsigned LFSR_W      = 31;
    localparam int unsigned TAP_HI      = 30;
    localparam int unsigned TAP_LO      = 27;
    localparam int unsigned FILL_CYCLES = 2;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/stoch_mult_sequencer_lfsr31.sv
// 31-bit Fibonacci LFSR (taps 30/27) with synchronous load and step enable.
// Reset value is fixed at elaboration so the asynchronous reset stays constant.
module lfsr31
    import stoch_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_SEED = 31'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/stoch_mult_sequencer.sv
// Per-job controller for the stochastic multiplier: seed, fill, accumulate, report.
// Define STOCH_SEQ_FREE_RUN_EN to let the LFSRs free-run instead of reseeding per job.
module stoch_mult_sequencer
    import stoch_pkg::*;
#(
    parameter int unsigned        WIN_LOG2 = 7,
    parameter int unsigned        PROB_W   = 4,
    parameter logic [LFSR_W-1:0]  SEED_A   = 31'd1,
    parameter logic [LFSR_W-1:0]  SEED_B   = 31'd2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [PROB_W-1:0]   req_pa,
    input  logic [PROB_W-1:0]   req_pb,
    input  logic                req_bipolar,
    input  logic                abort,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WIN_LOG2:0]   res_count,
    output logic [PROB_W-1:0]   res_prob,
    output logic                busy
);

    if (SEED_A == '0) begin : g_bad_seed_a
        $error("SEED_A must be nonzero");
    end
    if (SEED_B == '0 || SEED_B == SEED_A) begin : g_bad_seed_b
        $error("SEED_B must be nonzero and differ from SEED_A");
    end
    if (WIN_LOG2 < PROB_W) begin : g_bad_window
        $error("WIN_LOG2 must be >= PROB_W");
    end

    state_t state, state_next;

    logic [PROB_W-1:0]   pa_q, pb_q;
    logic                bipolar_q;
    logic                bit_a, bit_b, prod;
    logic [1:0]          fill_cnt;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   count, count_next;
    logic [LFSR_W-1:0]   lfsr_a, lfsr_b;
    logic                lfsr_load, lfsr_step;
    logic                accept, last_fill, last_accum;
    logic                unused_lfsr_bits;

    assign accept     = (state == IDLE) && req_valid;
    assign last_fill  = (fill_cnt == 2'(FILL_CYCLES - 1));
    assign last_accum = (win_cnt == '1);
    assign count_next = count + {{WIN_LOG2{1'b0}}, prod};

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef STOCH_SEQ_FREE_RUN_EN
    assign lfsr_load = 1'b0;
    assign lfsr_step = 1'b1;
`else
    assign lfsr_load = accept;
    assign lfsr_step = (state == FILL) || (state == ACCUM);
`endif

    lfsr31 #(.RESET_SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst   (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (SEED_A),
        .state (lfsr_a)
    );

    lfsr31 #(.RESET_SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst   (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (SEED_B),
        .state (lfsr_b)
    );

    assign unused_lfsr_bits = ^{lfsr_a[LFSR_W-1:PROB_W], lfsr_b[LFSR_W-1:PROB_W]};

    // Rescale the window count to PROB_W bits, saturating the full-window case.
    function automatic logic [PROB_W-1:0] scale_prob(input logic [WIN_LOG2:0] c);
        logic [WIN_LOG2:0] sh;
        sh = c >> (WIN_LOG2 - PROB_W);
        if ((sh >> PROB_W) != '0) begin
            return '1;
        end
        return sh[PROB_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (req_valid) state_next = FILL;
            FILL: begin
                if (abort)          state_next = IDLE;
                else if (last_fill) state_next = ACCUM;
            end
            ACCUM: begin
                if (abort)           state_next = IDLE;
                else if (last_accum) state_next = DONE;
            end
            DONE:  if (abort || res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Comparator and product registers run every cycle; FILL_CYCLES covers their latency.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pa_q      <= '0;
            pb_q      <= '0;
            bipolar_q <= 1'b0;
            bit_a     <= 1'b0;
            bit_b     <= 1'b0;
            prod      <= 1'b0;
            fill_cnt  <= '0;
            win_cnt   <= '0;
            count     <= '0;
            res_count <= '0;
            res_prob  <= '0;
            res_valid <= 1'b0;
        end else begin
            bit_a <= (lfsr_a[PROB_W-1:0] < pa_q);
            bit_b <= (lfsr_b[PROB_W-1:0] < pb_q);
            prod  <= bipolar_q ? ~(bit_a ^ bit_b) : (bit_a & bit_b);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        pa_q      <= req_pa;
                        pb_q      <= req_pb;
                        bipolar_q <= req_bipolar;
                        count     <= '0;
                        fill_cnt  <= '0;
                        win_cnt   <= '0;
                    end
                end
                FILL: begin
                    fill_cnt <= fill_cnt + 2'd1;
                end
                ACCUM: begin
                    count   <= count_next;
                    win_cnt <= win_cnt + 1'b1;
                    if (last_accum && !abort) begin
                        res_count <= count_next;
                        res_prob  <= scale_prob(count_next);
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (abort || res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_mult_sequencer.sv
// Scoreboard bench for stoch_mult_sequencer against a bitstream reference model.
module tb_stoch_mult_sequencer;

    localparam int WIN    = 128;
    localparam int SHIFT  = 3;
    localparam logic [30:0] SEED_A = 31'd1;
    localparam logic [30:0] SEED_B = 31'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_pa = '0;
    logic [3:0] req_pb = '0;
    logic       req_bipolar = 1'b0;
    logic       abort = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_count;
    logic [3:0] res_prob;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    typedef struct {
        int count;
        int prob;
    } exp_t;
    exp_t exp_q[$];

    stoch_mult_sequencer #(
        .WIN_LOG2 (7),
        .PROB_W   (4),
        .SEED_A   (SEED_A),
        .SEED_B   (SEED_B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pa      (req_pa),
        .req_pb      (req_pb),
        .req_bipolar (req_bipolar),
        .abort       (abort),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .res_prob    (res_prob),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release, i.e. how far a free-running LFSR has advanced.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [30:0] step_lfsr(input logic [30:0] s);
        return {s[29:0], s[27] ^ s[30]};
    endfunction

    // Count of product ones over the window starting 'start' steps after the seeds.
    function automatic exp_t model(input int pa, input int pb, input bit bip, input int start);
        logic [30:0] sa, sb;
        int ba, bb, cnt;
        exp_t e;
        sa = SEED_A;
        sb = SEED_B;
        for (int k = 0; k < start; k++) begin
            sa = step_lfsr(sa);
            sb = step_lfsr(sb);
        end
        cnt = 0;
        for (int i = 0; i < WIN; i++) begin
            ba = (int'(sa[3:0]) < pa) ? 1 : 0;
            bb = (int'(sb[3:0]) < pb) ? 1 : 0;
            if (bip) cnt += (ba == bb) ? 1 : 0;
            else     cnt += ba * bb;
            sa = step_lfsr(sa);
            sb = step_lfsr(sb);
        end
        e.count = cnt;
        e.prob  = ((cnt >> SHIFT) > 15) ? 15 : (cnt >> SHIFT);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got count %0d expected no result", res_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_count", int'(res_count), e.count);
                check("res_prob", int'(res_prob), e.prob);
            end
        end
    end

    // mode: 0 normal, 1 abort in FILL, 2 abort at ACCUM cycle 50, 3 abort in DONE,
    //       4 abort with handshake in DONE, 5 abort alongside the request in IDLE,
    //       6 reset pulse mid-ACCUM
    task automatic run_job(input int pa, input int pb, input bit bip, input int stall, input int mode);
        int cyc;
        int start;
        bit stopped;
        int held_count, held_prob;
        exp_t e;

        cyc = 0;
        while (!req_ready && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("req_ready_wait", int'(req_ready), 1);

        res_ready   = (stall == 0 && mode != 3 && mode != 4);
        req_pa      = 4'(pa);
        req_pb      = 4'(pb);
        req_bipolar = bip;
        req_valid   = 1'b1;
        abort       = (mode == 5);
        @(posedge clk); #1;
        req_valid   = 1'b0;
        abort       = 1'b0;
        req_pa      = 4'($urandom);
        req_pb      = 4'($urandom);
        req_bipolar = 1'($urandom);
`ifdef STOCH_SEQ_FREE_RUN_EN
        start = edges;
`else
        start = 0;
`endif
        if (mode == 0 || mode == 4 || mode == 5) begin
            e = model(pa, pb, bip, start);
            exp_q.push_back(e);
        end
        check("busy_after_accept", int'(busy), 1);

        cyc = 0;
        stopped = 0;
        while (cyc < 400) begin
            if (mode == 1 && cyc == 0)  abort = 1'b1;
            if (mode == 2 && cyc == 52) abort = 1'b1;
            if (mode == 6 && cyc == 42) begin
                #3 rst_n = 1'b1;
                #1;
                check("rst_res_valid", int'(res_valid), 0);
                check("rst_res_count", int'(res_count), 0);
                check("rst_res_prob", int'(res_prob), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_req_ready", int'(req_ready), 1);
                #2 rst_n = 1'b0;
                stopped = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (abort) begin
                abort = 1'b0;
                check("abort_busy", int'(busy), 0);
                check("abort_res_valid", int'(res_valid), 0);
                stopped = 1;
                break;
            end
            if (res_valid) break;
        end

        if (stopped) begin
            if (mode == 1 || mode == 2) begin
                cyc = 0;
                repeat (140) begin
                    @(posedge clk); #1;
                    if (res_valid) cyc++;
                end
                check("no_result_after_abort", cyc, 0);
            end
            return;
        end

        check("latency", cyc, 2 + WIN);
        held_count = int'(res_count);
        held_prob  = int'(res_prob);
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_res_valid", int'(res_valid), 1);
            check("stall_res_count", int'(res_count), held_count);
            check("stall_res_prob", int'(res_prob), held_prob);
            check("stall_req_ready", int'(req_ready), 0);
        end
        if (mode == 3) begin
            abort = 1'b1;
        end else if (mode == 4) begin
            abort = 1'b1;
            res_ready = 1'b1;
        end else begin
            res_ready = 1'b1;
        end
        @(posedge clk); #1;
        abort = 1'b0;
        res_ready = 1'b0;
        check("post_res_valid", int'(res_valid), 0);
        check("post_req_ready", int'(req_ready), 1);
    endtask

    initial begin
        #12;
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_res_count", int'(res_count), 0);
        check("reset_res_prob", int'(res_prob), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_req_ready", int'(req_ready), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;

        run_job(0, 0, 1'b0, 0, 0);
        run_job(0, 0, 1'b1, 0, 0);
        run_job(9, 5, 1'b1, 0, 0);
        run_job(9, 5, 1'b1, 0, 0);
        run_job(9, 5, 1'b0, 0, 0);
        run_job(9, 5, 1'b0, 0, 0);
        run_job(9, 5, 1'b1, 20, 0);
        run_job(7, 12, 1'b1, 0, 2);
        run_job(7, 12, 1'b1, 0, 0);
        run_job(15, 15, 1'b0, 0, 1);
        run_job(3, 11, 1'b0, 3, 3);
        run_job(13, 6, 1'b1, 2, 4);
        run_job(10, 4, 1'b0, 0, 5);
        run_job(9, 5, 1'b1, 0, 6);
        run_job(9, 5, 1'b1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion expected $finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
